// File: rtl/text_grid_mapper.sv
// text_grid_mapper: pipelined raster-to-character-cell mapper.
// Stage 0 registers the masked coordinates and the frame-synchronous scroll.
// Stages 1..N each perform one restoring-division step.
// Stage N+1 applies the row scroll, builds the linear index and registers the outputs.
// hs/vs/ad ride a plain shift register of the same depth.
`timescale 1ns/1ps
module text_grid_mapper #(
  parameter int COLS   = 32,
  parameter int ROWS   = 16,
  parameter int CELL_W = 40,
  parameter int CELL_H = 45,
  parameter int HW     = 11,
  parameter int VW     = 10,
  localparam int CX    = $clog2(COLS),
  localparam int CY    = $clog2(ROWS),
  localparam int XO    = $clog2(CELL_W),
  localparam int YO    = $clog2(CELL_H),
  localparam int IW    = $clog2(COLS * ROWS)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic [HW-1:0] hcount_in,
  input  logic [VW-1:0] vcount_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          ad_in,
  input  logic          nf_in,
  input  logic [CY-1:0] scroll_in,
  output logic [CX-1:0] col_out,
  output logic [CY-1:0] row_out,
  output logic [XO-1:0] x_off_out,
  output logic [YO-1:0] y_off_out,
  output logic [IW-1:0] cell_idx_out,
  output logic          in_grid_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out
);

  localparam int N   = (CX > CY) ? CX : CY;
  localparam int LAT = N + 2;
  // Wide enough to hold the largest shifted divisor next to a remainder.
  localparam int AWX = HW + CX + 1;
  localparam int AWY = VW + CY + 1;

  localparam logic [HW:0] GRID_W    = (HW + 1)'(COLS * CELL_W);
  localparam logic [VW:0] GRID_H    = (VW + 1)'(ROWS * CELL_H);
  localparam logic [CY:0] ROWS_L    = (CY + 1)'(ROWS);
  localparam bit          COLS_POW2 = (COLS == (1 << CX));

  // Pipeline state, index 0 is the input register, index j the j-th division step.
  logic [HW-1:0] rx_q   [0:N];
  logic [HW-1:0] rx_d   [0:N];
  logic [CX-1:0] qx_q   [0:N];
  logic [CX-1:0] qx_d   [0:N];
  logic [VW-1:0] ry_q   [0:N];
  logic [VW-1:0] ry_d   [0:N];
  logic [CY-1:0] qy_q   [0:N];
  logic [CY-1:0] qy_d   [0:N];
  logic          grid_q [0:N];
  logic          grid_d [0:N];
  logic [CY-1:0] scr_q  [0:N];
  logic [CY-1:0] scr_d  [0:N];

  logic [CY-1:0] scroll_q, scroll_d;
  logic          in_grid;
  logic [AWX-1:0] div_x;
  logic [AWY-1:0] div_y;
  logic           take_x, take_y;

  // Sideband delay line {hs, vs, ad}.
  logic [2:0] sb_q [0:LAT-1];
  logic [2:0] sb_d [0:LAT-1];

  // Output register.
  logic [CX-1:0] col_q,  col_d;
  logic [CY-1:0] row_q,  row_d;
  logic [XO-1:0] xoff_q, xoff_d;
  logic [YO-1:0] yoff_q, yoff_d;
  logic [IW-1:0] idx_q,  idx_d;
  logic          ing_q,  ing_d;
  logic [CY:0]   row_sum;
  logic [CY-1:0] row_s;

  // Input capture, scroll latch and the restoring-division steps.
  always_comb begin
    in_grid  = ({1'b0, hcount_in} < GRID_W) && ({1'b0, vcount_in} < GRID_H);
    // Scroll only moves on the new-frame pixel, and out-of-range requests are dropped.
    scroll_d = scroll_q;
    if (nf_in && ({1'b0, scroll_in} < ROWS_L)) begin
      scroll_d = scroll_in;
    end
    rx_d[0]   = in_grid ? hcount_in : '0;
    ry_d[0]   = in_grid ? vcount_in : '0;
    qx_d[0]   = '0;
    qy_d[0]   = '0;
    grid_d[0] = in_grid;
    scr_d[0]  = scroll_d;
    div_x     = '0;
    div_y     = '0;
    take_x    = 1'b0;
    take_y    = 1'b0;

    for (int j = 1; j <= N; j++) begin
      rx_d[j]   = rx_q[j-1];
      qx_d[j]   = qx_q[j-1];
      ry_d[j]   = ry_q[j-1];
      qy_d[j]   = qy_q[j-1];
      grid_d[j] = grid_q[j-1];
      scr_d[j]  = scr_q[j-1];
      // Quotient bits are produced MSB first, so each step shifts one bit in.
      if (j <= CX) begin
        div_x   = AWX'(CELL_W) << (CX - j);
        take_x  = (AWX'(rx_q[j-1]) >= div_x);
        if (take_x) begin
          rx_d[j] = HW'(AWX'(rx_q[j-1]) - div_x);
        end
        qx_d[j] = (qx_q[j-1] << 1) | CX'(take_x);
      end
      if (j <= CY) begin
        div_y   = AWY'(CELL_H) << (CY - j);
        take_y  = (AWY'(ry_q[j-1]) >= div_y);
        if (take_y) begin
          ry_d[j] = VW'(AWY'(ry_q[j-1]) - div_y);
        end
        qy_d[j] = (qy_q[j-1] << 1) | CY'(take_y);
      end
    end
  end

  // Scroll wrap, linear index and out-of-grid forcing for the output register.
  always_comb begin
    row_sum = {1'b0, qy_q[N]} + {1'b0, scr_q[N]};
    if (row_sum >= ROWS_L) begin
      row_sum = row_sum - ROWS_L;
    end
    row_s  = row_sum[CY-1:0];
    col_d  = qx_q[N];
    row_d  = row_s;
    xoff_d = XO'(rx_q[N]);
    yoff_d = YO'(ry_q[N]);
    if (COLS_POW2) begin
      idx_d = IW'({row_s, qx_q[N]});
    end else begin
      idx_d = IW'(row_s) * IW'(COLS) + IW'(qx_q[N]);
    end
    ing_d = grid_q[N];
    // Scroll would otherwise leak into row/idx for pixels outside the grid.
    if (!grid_q[N]) begin
      col_d  = '0;
      row_d  = '0;
      xoff_d = '0;
      yoff_d = '0;
      idx_d  = '0;
    end
  end

  // Sideband shift register next-state.
  always_comb begin
    sb_d[0] = {hs_in, vs_in, ad_in};
    for (int i = 1; i < LAT; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  // All pipeline state, cleared asynchronously so in-flight pixels are discarded.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      scroll_q <= '0;
      for (int i = 0; i <= N; i++) begin
        rx_q[i]   <= '0;
        qx_q[i]   <= '0;
        ry_q[i]   <= '0;
        qy_q[i]   <= '0;
        grid_q[i] <= 1'b0;
        scr_q[i]  <= '0;
      end
      for (int i = 0; i < LAT; i++) begin
        sb_q[i] <= '0;
      end
      col_q  <= '0;
      row_q  <= '0;
      xoff_q <= '0;
      yoff_q <= '0;
      idx_q  <= '0;
      ing_q  <= 1'b0;
    end else begin
      scroll_q <= scroll_d;
      rx_q     <= rx_d;
      qx_q     <= qx_d;
      ry_q     <= ry_d;
      qy_q     <= qy_d;
      grid_q   <= grid_d;
      scr_q    <= scr_d;
      sb_q     <= sb_d;
      col_q    <= col_d;
      row_q    <= row_d;
      xoff_q   <= xoff_d;
      yoff_q   <= yoff_d;
      idx_q    <= idx_d;
      ing_q    <= ing_d;
    end
  end

  assign col_out      = col_q;
  assign row_out      = row_q;
  assign x_off_out    = xoff_q;
  assign y_off_out    = yoff_q;
  assign cell_idx_out = idx_q;
  assign in_grid_out  = ing_q;
  assign hs_out       = sb_q[LAT-1][2];
  assign vs_out       = sb_q[LAT-1][1];
  assign ad_out       = sb_q[LAT-1][0];

endmodule
